// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud timing helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rxState_t;

    // Reload value for one full bit interval (interval = load + 1 clocks).
    function automatic int bitLoad(input int fclk, input int baud);
        return fclk / baud - 1;
    endfunction

    // Reload value for half a bit, used to land on the start-bit midpoint.
    function automatic int halfLoad(input int fclk, input int baud);
        return (fclk / baud) / 2 - 1;
    endfunction

    function automatic int cntWidth(input int fclk, input int baud);
        return $clog2(bitLoad(fclk, baud) + 1);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side view of the receiver plus the serial line it listens to.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter: loading L raises zero exactly L clocks later; holds at zero.
module uart_baud_cnt #(
    parameter int CNT_W   = 4,
    parameter int RST_VAL = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] count;

    // Load wins over counting; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CNT_W'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes rx, samples each bit at its midpoint,
// emits a one-cycle rx_valid for good frames and frame_err for a low stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FCLK = 50000000,
    parameter int BAUD = 115200
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.master rxIf
);
    localparam int BIT_LOAD  = bitLoad(FCLK, BAUD);
    localparam int HALF_LOAD = halfLoad(FCLK, BAUD);
    localparam int CNT_W     = cntWidth(FCLK, BAUD);

    rxState_t         state;
    logic             rxMeta;
    logic             rx_s;
    logic [2:0]       bitCnt;
    logic [7:0]       shiftReg;
    logic             baudLoad;
    logic [CNT_W-1:0] baudLoadVal;
    logic             baudZero;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            rxMeta <= rxIf.rx;
            rx_s   <= rxMeta;
        end
    end

    // Reload on start detection (half bit), start confirmation and every data sample (full bit).
    assign baudLoad = ((state == IDLE)  && !rx_s)
                   || ((state == START) && baudZero && !rx_s)
                   || ((state == DATA)  && baudZero);
    assign baudLoadVal = (state == IDLE) ? CNT_W'(HALF_LOAD) : CNT_W'(BIT_LOAD);

    uart_baud_cnt #(
        .CNT_W  (CNT_W),
        .RST_VAL(BIT_LOAD)
    ) baudCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (baudLoad),
        .load_val(baudLoadVal),
        .zero    (baudZero)
    );

    // Receive state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bitCnt         <= 3'd0;
            shiftReg       <= 8'h00;
            rxIf.rx_data   <= 8'h00;
            rxIf.rx_valid  <= 1'b0;
            rxIf.frame_err <= 1'b0;
            rxIf.busy      <= 1'b0;
        end else begin
            rxIf.rx_valid  <= 1'b0;
            rxIf.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state     <= START;
                        rxIf.busy <= 1'b1;
                    end
                end
                START: begin
                    if (baudZero) begin
                        if (!rx_s) begin
                            state  <= DATA;
                            bitCnt <= 3'd0;
                        end else begin
                            state     <= IDLE;
                            rxIf.busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (baudZero) begin
                        shiftReg <= {rx_s, shiftReg[7:1]};
                        if (bitCnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitCnt <= bitCnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (baudZero) begin
                        if (rx_s) begin
                            rxIf.rx_data  <= shiftReg;
                            rxIf.rx_valid <= 1'b1;
                            rxIf.busy     <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            rxIf.frame_err <= 1'b1;
                            state          <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so it cannot retrigger a start.
                    if (rx_s) begin
                        state     <= IDLE;
                        rxIf.busy <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rxIf.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a line driver plus a frame-level model.
module tb_uart_rx;
    localparam int FCLK      = 1000000;
    localparam int BAUD      = 100000;
    localparam int BIT_CLKS  = FCLK / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    // Cycles from driving the start edge (just after a clock edge) to seeing rx_valid.
    localparam int LATENCY   = 1 + 2 + HALF_CLKS + 9 * BIT_CLKS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    uart_rx_if bus ();

    uart_rx #(.FCLK(FCLK), .BAUD(BAUD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rxIf (bus)
    );

    always #5 clk = ~clk;

    int         cycle = 0;
    int         passCnt = 0;
    int         checkCnt = 0;
    logic [7:0] gotQ[$];
    int         gotT[$];
    int         errCnt = 0;
    int         viol = 0;
    logic       prevV = 1'b0;
    logic       prevE = 1'b0;
    logic       busyAfterValid = 1'b1;
    logic [7:0] lastGood = 8'h00;

    always @(posedge clk) cycle <= cycle + 1;

    // Observe outputs mid-cycle: log pulses and count pulse-rule violations.
    always @(negedge clk) begin
        if (bus.rx_valid && bus.frame_err) viol++;
        if ((bus.rx_valid && prevV) || (bus.frame_err && prevE)) viol++;
        if (prevV) busyAfterValid = bus.busy;
        if (bus.rx_valid) begin
            gotQ.push_back(bus.rx_data);
            gotT.push_back(cycle);
        end
        if (bus.frame_err) errCnt++;
        prevV = bus.rx_valid;
        prevE = bus.frame_err;
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLog();
        gotQ.delete();
        gotT.delete();
        errCnt = 0;
    endtask

    // Drive one 8N1 frame; t0 is the cycle count when the start edge was driven.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, output int t0);
        logic [9:0] bits;
        bits = {stopBit, b, 1'b0};
        t0 = cycle;
        for (int i = 0; i < 10; i++) begin
            bus.rx = bits[i];
            waitClk(BIT_CLKS);
        end
        bus.rx = 1'b1;
    endtask

    task automatic checkEq(input string name, input int actual, input int expected);
        checkCnt++;
        if (actual !== expected)
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
        else
            passCnt++;
    endtask

    task automatic test_reset();
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        waitClk(3);
        checkEq("reset rx_data", bus.rx_data, 8'h00);
        checkEq("reset rx_valid", bus.rx_valid, 0);
        checkEq("reset frame_err", bus.frame_err, 0);
        checkEq("reset busy", bus.busy, 0);
        rst_n = 1'b1;
        waitClk(5);
        checkEq("idle busy", bus.busy, 0);
    endtask

    task automatic test_glitch();
        int n;
        clearLog();
        bus.rx = 1'b0;
        waitClk(3);
        bus.rx = 1'b1;
        n = 0;
        while (bus.busy !== 1'b0 && n < 20) begin
            waitClk(1);
            n++;
        end
        checkCnt++;
        if (n > 7) $display("FAIL glitch busy: still busy after %0d clocks, required <= 7", n);
        else passCnt++;
        waitClk(120);
        checkEq("glitch rx_valid count", gotQ.size(), 0);
        checkEq("glitch frame_err count", errCnt, 0);
        checkEq("glitch rx_data", bus.rx_data, lastGood);
    endtask

    task automatic test_single();
        int t0;
        clearLog();
        sendFrame(8'h55, 1'b1, t0);
        waitClk(20);
        checkEq("single rx_valid count", gotQ.size(), 1);
        if (gotQ.size() >= 1) begin
            checkEq("single rx_data", gotQ[0], 8'h55);
            checkCnt++;
            if ((gotT[0] - t0) < LATENCY - 1 || (gotT[0] - t0) > LATENCY + 1)
                $display("FAIL single latency: got %0d expected %0d+-1", gotT[0] - t0, LATENCY);
            else passCnt++;
            lastGood = 8'h55;
        end
        checkEq("single frame_err count", errCnt, 0);
        checkEq("single busy after pulse", busyAfterValid, 0);
        checkEq("single pulse rules", viol, 0);
    endtask

    task automatic test_back_to_back();
        int t0, t1;
        clearLog();
        sendFrame(8'hA3, 1'b1, t0);
        sendFrame(8'h00, 1'b1, t1);
        waitClk(20);
        checkEq("b2b rx_valid count", gotQ.size(), 2);
        if (gotQ.size() >= 2) begin
            checkEq("b2b first byte", gotQ[0], 8'hA3);
            checkEq("b2b second byte", gotQ[1], 8'h00);
            checkEq("b2b spacing", gotT[1] - gotT[0], 10 * BIT_CLKS);
            lastGood = 8'h00;
        end
        checkEq("b2b frame_err count", errCnt, 0);
    endtask

    task automatic test_frame_err();
        int t0;
        clearLog();
        sendFrame(8'h3C, 1'b0, t0);
        waitClk(20);
        checkEq("ferr frame_err count", errCnt, 1);
        checkEq("ferr rx_valid count", gotQ.size(), 0);
        checkEq("ferr rx_data held", bus.rx_data, lastGood);
        checkEq("ferr busy idle", bus.busy, 0);
        checkEq("ferr pulse rules", viol, 0);
    endtask

    task automatic test_break();
        int t0;
        clearLog();
        bus.rx = 1'b0;
        waitClk(300);
        bus.rx = 1'b1;
        waitClk(20);
        checkEq("break frame_err count", errCnt, 1);
        checkEq("break rx_valid count", gotQ.size(), 0);
        sendFrame(8'h7E, 1'b1, t0);
        waitClk(20);
        checkEq("break recovery count", gotQ.size(), 1);
        if (gotQ.size() >= 1) begin
            checkEq("break recovery byte", gotQ[0], 8'h7E);
            lastGood = 8'h7E;
        end
        checkEq("break total frame_err", errCnt, 1);
    endtask

    task automatic test_reset_mid_frame();
        clearLog();
        bus.rx = 1'b0;
        waitClk(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'b1;
            waitClk(BIT_CLKS);
        end
        bus.rx = 1'b1;
        waitClk(BIT_CLKS / 2);
        rst_n = 1'b0;
        waitClk(5);
        rst_n = 1'b1;
        waitClk(150);
        lastGood = 8'h00;
        checkEq("rstmid rx_valid count", gotQ.size(), 0);
        checkEq("rstmid frame_err count", errCnt, 0);
        checkEq("rstmid rx_data", bus.rx_data, 8'h00);
        checkEq("rstmid busy", bus.busy, 0);
    endtask

    task automatic test_loopback();
        int t0;
        int bad;
        clearLog();
        for (int i = 0; i < 256; i++) sendFrame(8'(i), 1'b1, t0);
        waitClk(20);
        checkEq("loopback count", gotQ.size(), 256);
        bad = 0;
        for (int i = 0; i < 256 && i < gotQ.size(); i++)
            if (gotQ[i] !== 8'(i)) bad++;
        checkEq("loopback mismatched bytes", bad, 0);
        checkEq("loopback frame_err count", errCnt, 0);
        checkEq("loopback pulse rules", viol, 0);
        if (gotQ.size() > 0) lastGood = gotQ[gotQ.size() - 1];
    endtask

    task automatic test_random();
        logic [7:0] expQ[$];
        int         expErr;
        int         t0;
        int         bad;
        logic [7:0] b;
        logic       good;
        clearLog();
        expErr = 0;
        for (int i = 0; i < 30; i++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            sendFrame(b, good, t0);
            if (good) begin
                expQ.push_back(b);
                lastGood = b;
                waitClk($urandom_range(0, 15));
            end else begin
                expErr++;
                waitClk($urandom_range(3, 15));
            end
        end
        waitClk(20);
        checkEq("random rx_valid count", gotQ.size(), expQ.size());
        bad = 0;
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
            if (gotQ[i] !== expQ[i]) bad++;
        checkEq("random mismatched bytes", bad, 0);
        checkEq("random frame_err count", errCnt, expErr);
        checkEq("random final rx_data", bus.rx_data, lastGood);
        checkEq("random pulse rules", viol, 0);
    endtask

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_glitch();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_break();
        test_reset_mid_frame();
        test_loopback();
        test_random();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
